// File: rtl/reg_write_stage.sv
// Write-back stage: one staged register write with one-hot array enables,
// and read-port forwarding from the staged write. X(NREG-1) is hardwired zero.
module reg_write_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     hold,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  input  logic [DATA_W-1:0]        arr_data_a,
  input  logic [DATA_W-1:0]        arr_data_b,
  output logic [(2**ADDR_W)-1:0]   word_en,
  output logic [DATA_W-1:0]        word_data,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic                     busy
);

  localparam int unsigned NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(NREG - 1);

  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;

  // Stage load: hold freezes the register and drops the incoming request.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (!hold) begin
      wb_valid_d = wr_en && (wr_addr != ZERO_REG);
      wb_addr_d  = wr_addr;
      wb_data_d  = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Array enables decode from staged state only; the zero register is never written.
  always_comb begin
    word_en = '0;
    if (wb_valid_q) begin
      word_en[wb_addr_q] = 1'b1;
    end
    word_en[NREG-1] = 1'b0;
  end

  assign word_data = wb_data_q;
  assign busy      = wb_valid_q;

  always_comb begin
    rd_data_a = arr_data_a;
    if (rd_addr_a == ZERO_REG) begin
      rd_data_a = '0;
    end else if (wb_valid_q && (rd_addr_a == wb_addr_q)) begin
      rd_data_a = wb_data_q;
    end
  end

  always_comb begin
    rd_data_b = arr_data_b;
    if (rd_addr_b == ZERO_REG) begin
      rd_data_b = '0;
    end else if (wb_valid_q && (rd_addr_b == wb_addr_q)) begin
      rd_data_b = wb_data_q;
    end
  end

endmodule
